// File: rtl/clk_tick_pkg.sv
// rtl/clk_tick_pkg.sv - shared constants, types and sizing helper for the clock-enable generator
package clk_tick_pkg;
  localparam int unsigned CLK_HZ  = 100_000_000;
  localparam int unsigned DEF_DIV = 50_000;
  localparam int          DIV_W   = 32;

  typedef logic [DIV_W-1:0] div_t;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_tick_chan.sv
// rtl/clk_tick_chan.sv - one divider channel: counter, active/shadow divisor, tick and square wave
module clk_tick_chan #(
  parameter int          DIV_W   = 32,
  parameter int unsigned DEF_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr_hit,
  input  logic [DIV_W-1:0] wr_data,
  input  logic             sync,
  output logic             tick,
  output logic             sq
);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt, active_div, shadow_div;
  logic             pend, run, last;

  assign run  = en && (active_div != '0);
  assign last = (cnt == active_div - ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      active_div <= RST_DIV;
      shadow_div <= RST_DIV;
      pend       <= 1'b0;
      tick       <= 1'b0;
      sq         <= 1'b0;
    end else if (sync) begin
      // Phase alignment: older shadow goes live, a same-cycle write stays pending.
      cnt  <= '0;
      sq   <= 1'b0;
      tick <= 1'b0;
      if (pend) active_div <= shadow_div;
      if (wr_hit) begin
        shadow_div <= wr_data;
        pend       <= 1'b1;
      end else begin
        pend <= 1'b0;
      end
    end else begin
      if (wr_hit) shadow_div <= wr_data;
      if (!run) begin
        tick <= 1'b0;
        if (wr_hit) begin
          active_div <= wr_data;
          cnt        <= '0;
          pend       <= 1'b0;
        end
      end else if (last) begin
        // Period boundary: the finishing tick keeps the old divisor, the next uses the newest.
        tick <= 1'b1;
        sq   <= ~sq;
        cnt  <= '0;
        if (wr_hit) begin
          active_div <= wr_data;
          pend       <= 1'b0;
        end else if (pend) begin
          active_div <= shadow_div;
          pend       <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
        cnt  <= cnt + ONE;
        if (wr_hit) pend <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/clk_tick_gen.sv
// rtl/clk_tick_gen.sv - multi-channel programmable tick/square generator with divisor write port
// Define CLKDIV_SYNC_EN to add the global sync input that realigns all channel phases.
module clk_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int          NCH     = 4,
  parameter int          DIV_W   = clk_tick_pkg::DIV_W,
  parameter int unsigned DEF_DIV = clk_tick_pkg::DEF_DIV
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef CLKDIV_SYNC_EN
  input  logic                    sync,
`endif
  input  logic [NCH-1:0]          ch_en,
  input  logic                    div_wr,
  input  logic [sel_w(NCH)-1:0]   div_sel,
  input  logic [DIV_W-1:0]        div_data,
  output logic                    div_ack,
  output logic                    div_err,
  output logic [NCH-1:0]          tick,
  output logic [NCH-1:0]          sq
);
  logic [31:0] sel_ext;
  logic        sel_ok;
  logic        sync_pulse;

  assign sel_ext = 32'(div_sel);
  assign sel_ok  = sel_ext < 32'(NCH);

`ifdef CLKDIV_SYNC_EN
  assign sync_pulse = sync;
`else
  assign sync_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      div_ack <= div_wr && sel_ok;
      div_err <= div_wr && !sel_ok;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_tick_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (ch_en[i]),
      .wr_hit  (div_wr && sel_ok && (sel_ext == 32'(i))),
      .wr_data (div_data),
      .sync    (sync_pulse),
      .tick    (tick[i]),
      .sq      (sq[i])
    );
  end
endmodule
